// File: rtl/sha256_msg_padder_if.sv
// Handshake and scheduler-load bundle for the SHA-256 message padder.
// The padder plugs in through the slave view. The upstream source, the
// scheduler and the compression core share the master view.
interface sha256_msg_padder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [2:0]  in_bytes;
  logic        start_new_block;
  logic        write_enable_out;
  logic [3:0]  message_word_addr;
  logic [31:0] message_word_out;
  logic        block_ready;
  logic        block_ack;
  logic        msg_done;
  logic        busy;

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, block_ack,
    output in_ready, start_new_block, write_enable_out, message_word_addr,
           message_word_out, block_ready, msg_done, busy
  );

  modport master (
    output in_valid, in_data, in_last, in_bytes, block_ack,
    input  in_ready, start_new_block, write_enable_out, message_word_addr,
           message_word_out, block_ready, msg_done, busy
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder. It takes a big-endian word stream, appends the
// 0x80 marker, the zero fill and the 64-bit bit length, and writes each
// 512-bit block as 16 word writes. After every block it holds until the
// core acknowledges it.
module sha256_msg_padder #(
  parameter int LEN_BITS = 64
) (
  input  logic               clk,
  input  logic               reset,
  sha256_msg_padder_if.slave bus
);

  typedef enum logic [1:0] {LOAD, PAD, LEN, WAIT} state_t;

  state_t              r_state, w_nextState;
  logic [3:0]          r_addr, w_addr;
  logic [LEN_BITS-1:0] r_len, w_len;
  logic                r_markerPending, w_markerPending;
  logic                r_padToLen, w_padToLen;
  logic                r_lastSeen, w_lastSeen;
  logic                r_lenWritten, w_lenWritten;
  logic                r_inReady, w_inReady;
  logic                r_we, w_we;
  logic [3:0]          r_wordAddr, w_wordAddr;
  logic [31:0]         r_wordOut, w_wordOut;
  logic                r_blockReady, w_blockReady;
  logic                r_msgDone, w_msgDone;
  logic                r_busy, w_busy;
  logic                w_accept;
  logic [5:0]          w_byteBits;
  logic [31:0]         w_keepMask, w_markerBits;
  logic [63:0]         w_len64;

  assign w_accept     = bus.in_valid && r_inReady;
  assign w_byteBits   = {bus.in_bytes, 3'b000};
  assign w_keepMask   = ~(32'hFFFF_FFFF >> w_byteBits);
  assign w_markerBits = 32'h8000_0000 >> w_byteBits;
  assign w_len64      = 64'(r_len);

  // Next-state and next-output logic. Every output is computed here one
  // cycle early and then registered. Once the marker is written, its
  // address decides whether the length still fits in this block (fill to
  // 13, then LEN) or needs another block (fill to 15, then WAIT).
  always_comb begin
    w_nextState     = r_state;
    w_addr          = r_addr;
    w_len           = r_len;
    w_markerPending = r_markerPending;
    w_padToLen      = r_padToLen;
    w_lastSeen      = r_lastSeen;
    w_lenWritten    = r_lenWritten;
    w_busy          = r_busy;
    w_we            = 1'b0;
    w_wordAddr      = r_wordAddr;
    w_wordOut       = r_wordOut;
    w_blockReady    = 1'b0;
    w_msgDone       = 1'b0;

    case (r_state)
      LOAD: begin
        if (w_accept) begin
          w_we       = 1'b1;
          w_wordAddr = r_addr;
          w_addr     = r_addr + 4'd1;
          w_busy     = 1'b1;
          w_len      = r_len + LEN_BITS'(w_byteBits);
          if (!bus.in_last) begin
            w_wordOut = bus.in_data;
            if (r_addr == 4'd15) w_nextState = WAIT;
          end else begin
            w_lastSeen = 1'b1;
            if (bus.in_bytes >= 3'd4) begin
              w_wordOut       = bus.in_data;
              w_markerPending = 1'b1;
              w_nextState     = (r_addr == 4'd15) ? WAIT : PAD;
            end else begin
              w_wordOut  = (bus.in_data & w_keepMask) | w_markerBits;
              w_padToLen = (r_addr != 4'd14);
              if (r_addr == 4'd13)      w_nextState = LEN;
              else if (r_addr == 4'd15) w_nextState = WAIT;
              else                      w_nextState = PAD;
            end
          end
        end
      end

      PAD: begin
        w_we       = 1'b1;
        w_wordAddr = r_addr;
        w_addr     = r_addr + 4'd1;
        if (r_markerPending) begin
          w_wordOut       = 32'h8000_0000;
          w_markerPending = 1'b0;
          w_padToLen      = (r_addr != 4'd14);
          if (r_addr == 4'd13)      w_nextState = LEN;
          else if (r_addr == 4'd15) w_nextState = WAIT;
        end else begin
          w_wordOut = 32'h0;
          if (r_padToLen && r_addr == 4'd13)       w_nextState = LEN;
          else if (!r_padToLen && r_addr == 4'd15) w_nextState = WAIT;
        end
      end

      LEN: begin
        w_we       = 1'b1;
        w_wordAddr = r_addr;
        w_addr     = r_addr + 4'd1;
        if (r_addr == 4'd14) begin
          w_wordOut = w_len64[63:32];
        end else begin
          w_wordOut    = w_len64[31:0];
          w_lenWritten = 1'b1;
          w_nextState  = WAIT;
        end
      end

      WAIT: begin
        w_blockReady = 1'b1;
        if (r_blockReady && bus.block_ack) begin
          w_blockReady = 1'b0;
          if (!r_lastSeen) begin
            w_nextState = LOAD;
          end else if (r_lenWritten) begin
            w_nextState  = LOAD;
            w_msgDone    = 1'b1;
            w_busy       = 1'b0;
            w_len        = '0;
            w_lastSeen   = 1'b0;
            w_lenWritten = 1'b0;
          end else begin
            w_nextState = PAD;
            w_padToLen  = 1'b1;
          end
        end
      end

      default: w_nextState = LOAD;
    endcase

    w_inReady = (w_nextState == LOAD);
  end

  // State and output registers. Reset aborts any message in flight at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= LOAD;
      r_addr          <= 4'd0;
      r_len           <= '0;
      r_markerPending <= 1'b0;
      r_padToLen      <= 1'b0;
      r_lastSeen      <= 1'b0;
      r_lenWritten    <= 1'b0;
      r_inReady       <= 1'b0;
      r_we            <= 1'b0;
      r_wordAddr      <= 4'd0;
      r_wordOut       <= 32'h0;
      r_blockReady    <= 1'b0;
      r_msgDone       <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_state         <= w_nextState;
      r_addr          <= w_addr;
      r_len           <= w_len;
      r_markerPending <= w_markerPending;
      r_padToLen      <= w_padToLen;
      r_lastSeen      <= w_lastSeen;
      r_lenWritten    <= w_lenWritten;
      r_inReady       <= w_inReady;
      r_we            <= w_we;
      r_wordAddr      <= w_wordAddr;
      r_wordOut       <= w_wordOut;
      r_blockReady    <= w_blockReady;
      r_msgDone       <= w_msgDone;
      r_busy          <= w_busy;
    end
  end

  assign bus.in_ready          = r_inReady;
  assign bus.start_new_block   = r_we;
  assign bus.write_enable_out  = r_we;
  assign bus.message_word_addr = r_wordAddr;
  assign bus.message_word_out  = r_wordOut;
  assign bus.block_ready       = r_blockReady;
  assign bus.msg_done          = r_msgDone;
  assign bus.busy              = r_busy;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Testbench for sha256_msg_padder. Expected block contents come from a
// byte-level padding model (message, 0x80, zeros to 56 mod 64, 64-bit
// length) and from hand-computed constants for the directed cases.
module tb_sha256_msg_padder;

  logic clk = 1'b0;
  logic reset;

  sha256_msg_padder_if bus();

  sha256_msg_padder #(.LEN_BITS(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  bytes;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w15;
  } vec_t;

  vec_t        vecs[5];
  int          nVectors = 0;
  int          nMiscompares = 0;
  logic [35:0] gotWrites[$];
  int          msgDoneCount = 0;
  int          violations = 0;
  logic [7:0]  txMsg[$];
  logic [35:0] expWrites[$];
  logic [31:0] tailFill;
  bit          gapsOn;
  bit          ackRandom;
  int          ackDelay;
  int          gotBase = 0;

  // Monitor: records every scheduler write and counts protocol-rule breaks.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.write_enable_out === 1'b1)
        gotWrites.push_back({bus.message_word_addr, bus.message_word_out});
      if (bus.msg_done === 1'b1) msgDoneCount++;
      if (bus.start_new_block !== bus.write_enable_out) violations++;
      if (bus.block_ready && (bus.write_enable_out || bus.in_ready)) violations++;
      if (bus.write_enable_out && bus.message_word_addr == 4'hF && bus.in_ready) violations++;
      if (bus.write_enable_out && !bus.busy) violations++;
      if (bus.msg_done && bus.busy) violations++;
    end
  end

  // Core model: acknowledges each finished block after a fixed or random delay.
  initial begin
    int d;
    bus.block_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.block_ready === 1'b1) begin
        d = ackRandom ? int'($urandom_range(0, 6)) : ackDelay;
        repeat (d) @(negedge clk);
        bus.block_ack = 1'b1;
        @(negedge clk);
        bus.block_ack = 1'b0;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #800000;
    $display("[TB] FAIL watchdog: run still active at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [35:0] gotWord(input int i);
    if (gotBase + i < gotWrites.size()) return gotWrites[gotBase + i];
    return 'x;
  endfunction

  // Reference padding built from the message bytes, split into 16-word blocks.
  task automatic buildExpected();
    logic [7:0]  p[$];
    logic [63:0] bitLen;
    p = txMsg;
    bitLen = 64'(txMsg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bitLen[8*i +: 8]);
    expWrites.delete();
    for (int w = 0; w < p.size() / 4; w++)
      expWrites.push_back({4'(w % 16), p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]});
  endtask

  task automatic sendWord(input logic [31:0] d, input logic l, input logic [2:0] b,
                          output bit ok);
    int waited;
    ok = 1'b1;
    if (gapsOn && $urandom_range(0, 3) == 0) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_bytes = b;
    waited = 0;
    while (!bus.in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      nVectors++;
      nMiscompares++;
      $display("[TB] FAIL accept timeout: in_ready 0 for %0d cycles, want 1", waited);
      bus.in_valid = 1'b0;
      ok = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Streams txMsg into the padder and compares every write with the model.
  task automatic applyStimulus(input bit emptyTerm);
    int          n, full, rem, waited, doneBase, violBase, gotCount;
    logic [31:0] wd;
    bit          ok;
    n = txMsg.size();
    full = n / 4;
    rem = n % 4;
    buildExpected();
    gotBase = gotWrites.size();
    doneBase = msgDoneCount;
    violBase = violations;
    ok = 1'b1;
    for (int w = 0; w < full && ok; w++) begin
      wd = {txMsg[4*w], txMsg[4*w+1], txMsg[4*w+2], txMsg[4*w+3]};
      sendWord(wd, (w == full - 1) && (rem == 0) && !emptyTerm, 3'd4, ok);
    end
    if (ok && rem != 0) begin
      wd = tailFill;
      for (int k = 0; k < rem; k++) wd[31-8*k -: 8] = txMsg[4*full + k];
      sendWord(wd, 1'b1, 3'(rem), ok);
    end else if (ok && (full == 0 || emptyTerm)) begin
      sendWord(tailFill, 1'b1, 3'd0, ok);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    waited = 0;
    while (msgDoneCount == doneBase && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    repeat (3) @(negedge clk);
    gotCount = gotWrites.size() - gotBase;
    checkOutput("msg_done pulse count", 64'(msgDoneCount - doneBase), 64'd1);
    checkOutput("write count", 64'(gotCount), 64'(expWrites.size()));
    for (int i = 0; i < expWrites.size(); i++)
      checkOutput($sformatf("write %0d {addr,word}", i), 64'(gotWord(i)), 64'(expWrites[i]));
    checkOutput("busy after msg_done", 64'(bus.busy), 64'd0);
    checkOutput("handshake rule violations", 64'(violations - violBase), 64'd0);
  endtask

  task automatic checkAllIdle(input string tag);
    checkOutput({tag, " in_ready"}, 64'(bus.in_ready), 64'd0);
    checkOutput({tag, " start_new_block"}, 64'(bus.start_new_block), 64'd0);
    checkOutput({tag, " write_enable_out"}, 64'(bus.write_enable_out), 64'd0);
    checkOutput({tag, " message_word_addr"}, 64'(bus.message_word_addr), 64'd0);
    checkOutput({tag, " message_word_out"}, 64'(bus.message_word_out), 64'd0);
    checkOutput({tag, " block_ready"}, 64'(bus.block_ready), 64'd0);
    checkOutput({tag, " msg_done"}, 64'(bus.msg_done), 64'd0);
    checkOutput({tag, " busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    bit ok;
    int doneBase;
    int n;

    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 32'h0;
    bus.in_last  = 1'b0;
    bus.in_bytes = 3'd0;
    gapsOn    = 1'b0;
    ackRandom = 1'b0;
    ackDelay  = 2;
    tailFill  = 32'h0;

    vecs[0] = '{32'h6162_6300, 3'd3, 32'h6162_6380, 32'h0,         32'h18};
    vecs[1] = '{32'h0000_0000, 3'd0, 32'h8000_0000, 32'h0,         32'h0};
    vecs[2] = '{32'hAABB_CCDD, 3'd1, 32'hAA80_0000, 32'h0,         32'h8};
    vecs[3] = '{32'h1234_5678, 3'd2, 32'h1234_8000, 32'h0,         32'h10};
    vecs[4] = '{32'hDEAD_BEEF, 3'd4, 32'hDEAD_BEEF, 32'h8000_0000, 32'h20};

    repeat (3) @(negedge clk);
    checkAllIdle("reset");
    reset = 1'b0;
    @(negedge clk);
    checkOutput("in_ready after reset", 64'(bus.in_ready), 64'd1);

    // Single-word messages from the table.
    for (int v = 0; v < 5; v++) begin
      txMsg.delete();
      for (int k = 0; k < int'(vecs[v].bytes); k++)
        txMsg.push_back(vecs[v].data[31-8*k -: 8]);
      tailFill = vecs[v].data;
      applyStimulus(1'b0);
      checkOutput($sformatf("vec%0d word0", v), 64'(gotWord(0)), 64'({4'd0, vecs[v].w0}));
      checkOutput($sformatf("vec%0d word1", v), 64'(gotWord(1)), 64'({4'd1, vecs[v].w1}));
      checkOutput($sformatf("vec%0d word15", v), 64'(gotWord(15)), 64'({4'd15, vecs[v].w15}));
    end

    // 56 bytes: marker at addr 14, length spills into a second block.
    txMsg.delete();
    for (int k = 0; k < 56; k++) txMsg.push_back(8'($urandom));
    applyStimulus(1'b0);
    checkOutput("56B blk1 addr14", 64'(gotWord(14)), 64'({4'd14, 32'h8000_0000}));
    checkOutput("56B blk1 addr15", 64'(gotWord(15)), 64'({4'd15, 32'h0}));
    checkOutput("56B blk2 addr15", 64'(gotWord(31)), 64'({4'd15, 32'h1C0}));

    // 64 bytes: pure data block, then marker block.
    txMsg.delete();
    for (int k = 0; k < 64; k++) txMsg.push_back(8'($urandom));
    applyStimulus(1'b0);
    checkOutput("64B blk2 addr0", 64'(gotWord(16)), 64'({4'd0, 32'h8000_0000}));
    checkOutput("64B blk2 addr15", 64'(gotWord(31)), 64'({4'd15, 32'h200}));

    // Backpressure: in_valid held high while the core takes 70 cycles to ack.
    ackDelay = 70;
    txMsg.delete();
    for (int k = 0; k < 80; k++) txMsg.push_back(8'($urandom));
    applyStimulus(1'b0);
    checkOutput("backpressure resume word",
                64'(gotWord(16)), 64'({4'd0, txMsg[64], txMsg[65], txMsg[66], txMsg[67]}));
    ackDelay = 2;

    // Reset right after the addr 7 write aborts the message.
    doneBase = msgDoneCount;
    for (int w = 0; w < 8; w++) sendWord($urandom, 1'b0, 3'd4, ok);
    #1 reset = 1'b1;
    #1 checkAllIdle("abort");
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("no msg_done on abort", 64'(msgDoneCount - doneBase), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    txMsg.delete();
    txMsg.push_back(8'h61);
    txMsg.push_back(8'h62);
    txMsg.push_back(8'h63);
    tailFill = 32'h6162_6300;
    applyStimulus(1'b0);
    checkOutput("post-abort abc word0", 64'(gotWord(0)), 64'({4'd0, vecs[0].w0}));
    checkOutput("post-abort abc word15", 64'(gotWord(15)), 64'({4'd15, vecs[0].w15}));

    // Randomized messages with input gaps and random ack latency.
    gapsOn = 1'b1;
    ackRandom = 1'b1;
    for (int m = 0; m < 25; m++) begin
      n = int'($urandom_range(0, 140));
      txMsg.delete();
      for (int k = 0; k < n; k++) txMsg.push_back(8'($urandom));
      tailFill = $urandom;
      applyStimulus(1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
